// File: rtl/seg_to_hex_capture.sv
// Watches a multiplexed 7-segment display bus, debounces each digit's dwell and
// assembles the four decoded digits into hex frames handed off over valid/ready.
module seg_to_hex_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:7]  seg,
  input  logic [3:0]  an,
  output logic [15:0] out_value,
  output logic [3:0]  out_dp,
  output logic [3:0]  out_bad,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    COMMIT  = 1'b1
  } state_t;

  logic [0:7]  seg_fix;
  logic [3:0]  an_fix;
  logic [0:7]  seg_q;
  logic [3:0]  an_q;
  logic [0:7]  seg_prev_q;
  logic [3:0]  an_prev_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        one_hot;
  logic        same_sample;
  logic        capture;
  logic [3:0]  dec_nib;
  logic        dec_bad;
  logic        dec_dp;
  logic [3:0]  slot_nib_q [4];
  logic [3:0]  slot_dp_q;
  logic [3:0]  slot_bad_q;
  logic [3:0]  mask_q;
  logic [3:0]  mask_d;
  logic [15:0] frame_value;
  state_t      state_q;
  logic        commit_load;
  logic [15:0] out_value_q;
  logic [3:0]  out_dp_q;
  logic [3:0]  out_bad_q;
  logic        out_valid_q;
  logic        overrun_q;

  assign seg_fix = SEG_ACTIVE_LOW ? ~seg : seg;
  assign an_fix  = AN_ACTIVE_LOW  ? ~an  : an;

  // Sample register plus a copy of last cycle's sample for the stability compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= '0;
      an_q       <= '0;
      seg_prev_q <= '0;
      an_prev_q  <= '0;
      cnt_q      <= '0;
    end else begin
      seg_q      <= seg_fix;
      an_q       <= an_fix;
      seg_prev_q <= seg_q;
      an_prev_q  <= an_q;
      cnt_q      <= cnt_d;
    end
  end

  assign one_hot     = (an_q != 4'b0000) && ((an_q & (an_q - 4'd1)) == 4'b0000);
  assign same_sample = ({an_q, seg_q} == {an_prev_q, seg_prev_q});

  always_comb begin
    cnt_d = cnt_q;
    if (!one_hot) begin
      cnt_d = 8'd0;
    end else if (same_sample) begin
      cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd1;
    end
  end

  // Fires only on the edge into saturation, so a long dwell captures once.
  assign capture = one_hot && (cnt_q != STABLE) && (cnt_d == STABLE);

  always_comb begin
    dec_bad = 1'b0;
    dec_dp  = seg_q[7];
    case (seg_q[0:6])
      7'b1111110: dec_nib = 4'h0;
      7'b0110000: dec_nib = 4'h1;
      7'b1101101: dec_nib = 4'h2;
      7'b1111001: dec_nib = 4'h3;
      7'b0110011: dec_nib = 4'h4;
      7'b1011011: dec_nib = 4'h5;
      7'b1011111: dec_nib = 4'h6;
      7'b1110000: dec_nib = 4'h7;
      7'b1111111: dec_nib = 4'h8;
      7'b1111011: dec_nib = 4'h9;
      7'b1110111: dec_nib = 4'hA;
      7'b0011111: dec_nib = 4'hB;
      7'b1001110: dec_nib = 4'hC;
      7'b0111101: dec_nib = 4'hD;
      7'b1001111: dec_nib = 4'hE;
      7'b1000111: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_bad = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_dp_q  <= '0;
      slot_bad_q <= '0;
      for (int i = 0; i < 4; i++) begin
        slot_nib_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (an_q[i]) begin
          slot_nib_q[i] <= dec_nib;
          slot_dp_q[i]  <= dec_dp;
          slot_bad_q[i] <= dec_bad;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_frame
      assign frame_value[4*gi +: 4] = slot_nib_q[gi];
    end
  endgenerate

  // A capture landing in the COMMIT cycle survives the clear and starts the next frame.
  always_comb begin
    mask_d = mask_q;
    if (state_q == COMMIT) begin
      mask_d = 4'b0000;
    end
    if (capture) begin
      mask_d = mask_d | an_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign commit_load = (state_q == COMMIT) && (!out_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      out_value_q <= '0;
      out_dp_q    <= '0;
      out_bad_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (mask_q == 4'b1111) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          state_q <= COLLECT;
          if (commit_load) begin
            out_value_q <= frame_value;
            out_dp_q    <= slot_dp_q;
            out_bad_q   <= slot_bad_q;
          end else begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase
      out_valid_q <= commit_load || (out_valid_q && !out_ready);
    end
  end

  assign out_value = out_value_q;
  assign out_dp    = out_dp_q;
  assign out_bad   = out_bad_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_to_hex_capture.sv
// Bench for seg_to_hex_capture: drives scanned 7-segment digits into a normal and
// an inverted-polarity instance and checks presented frames against a queue.
module tb_seg_to_hex_capture;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bad;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:7]  seg = '0;
  logic [3:0]  an = '0;
  logic        out_ready = 1'b1;
  logic [15:0] out_value;
  logic [3:0]  out_dp;
  logic [3:0]  out_bad;
  logic        out_valid;
  logic        overrun;

  logic [0:7]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] inv_value;
  logic [3:0]  inv_dp;
  logic [3:0]  inv_bad;
  logic        inv_valid;
  logic        inv_overrun;

  int n_vec = 0;
  int n_bad = 0;
  frame_t sb_q[$];

  assign seg_n = ~seg;
  assign an_n  = ~an;

  always #5 clk = ~clk;

  seg_to_hex_capture dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .out_value(out_value), .out_dp(out_dp), .out_bad(out_bad),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  seg_to_hex_capture #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .seg(seg_n), .an(an_n),
    .out_value(inv_value), .out_dp(inv_dp), .out_bad(inv_bad),
    .out_valid(inv_valid), .out_ready(out_ready), .overrun(inv_overrun)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input int k, input logic [6:0] g, input logic dp, input int hold);
    an  = 4'(1 << k);
    seg = {g, dp};
    repeat (hold) tick();
  endtask

  task automatic send_frame(input logic [15:0] v, input logic [3:0] dp, input int hold, input bit push);
    frame_t f;
    for (int k = 3; k >= 0; k--) begin
      drive_digit(k, glyph(v[4*k +: 4]), dp[k], hold);
    end
    f.v = v;
    f.dp = dp;
    f.bad = 4'b0000;
    if (push) sb_q.push_back(f);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (out_value !== 16'h0 || out_dp !== 4'h0 || out_bad !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_data: got value=%h dp=%b bad=%b want 0000/0000/0000", out_value, out_dp, out_bad);
    end
    n_vec++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got valid=%b overrun=%b want 0/0", out_valid, overrun);
    end
    n_vec++;
    if (inv_value !== 16'h0 || inv_valid !== 1'b0 || inv_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_inv: got value=%h valid=%b overrun=%b want 0000/0/0", inv_value, inv_valid, inv_overrun);
    end
    rst = 1'b0;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_scan();
    frame_t exp;
    out_ready = 1'b1;
    send_frame(16'h1234, 4'b0000, 6, 1'b1);
    // Digit 0 entered the sample register 6 cycles ago: valid is due on the next edge.
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL scan_early: got valid=%b want 0 one cycle before latency", out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL scan_latency: got valid=%b want 1", out_valid);
    end
    exp = sb_q.pop_front();
    n_vec++;
    if (out_value !== exp.v || out_dp !== exp.dp || out_bad !== exp.bad) begin
      n_bad++;
      $display("FAIL scan_frame: got %h/%b/%b want %h/%b/%b", out_value, out_dp, out_bad, exp.v, exp.dp, exp.bad);
    end
    n_vec++;
    if (inv_valid !== 1'b1 || inv_value !== exp.v || inv_bad !== 4'b0000) begin
      n_bad++;
      $display("FAIL scan_inverted: got valid=%b value=%h bad=%b want 1/%h/0000", inv_valid, inv_value, inv_bad, exp.v);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || inv_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL scan_one_cycle: got valid=%b inv_valid=%b want 0/0", out_valid, inv_valid);
    end
    $display("scan: frame %h", exp.v);
  endtask

  task automatic test_glitch();
    frame_t exp;
    bit ok;
    drive_digit(3, glyph(4'h7), 1'b0, 6);
    drive_digit(2, glyph(4'h8), 1'b0, 6);
    drive_digit(1, glyph(4'h9), 1'b0, 6);
    drive_digit(0, glyph(4'h8), 1'b0, 3);
    drive_digit(0, glyph(4'h1), 1'b0, 6);
    exp.v = 16'h7891; exp.dp = 4'b0000; exp.bad = 4'b0000;
    sb_q.push_back(exp);
    wait_valid(30, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL glitch_timeout: got valid=0 want 1 within 30 cycles");
    end
    exp = sb_q.pop_front();
    n_vec++;
    if (out_value !== exp.v) begin
      n_bad++;
      $display("FAIL glitch_value: got %h want %h", out_value, exp.v);
    end
    repeat (2) tick();
    $display("glitch: frame %h", exp.v);
  endtask

  task automatic test_dp_bad();
    frame_t exp;
    bit ok;
    send_frame(16'hEFB0, 4'b0100, 4, 1'b1);
    wait_valid(30, ok);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || out_value !== exp.v || out_dp !== exp.dp || out_bad !== exp.bad) begin
      n_bad++;
      $display("FAIL dp_frame: got ok=%b %h/%b/%b want %h/%b/%b", ok, out_value, out_dp, out_bad, exp.v, exp.dp, exp.bad);
    end
    tick();
    drive_digit(3, glyph(4'h1), 1'b0, 4);
    drive_digit(2, glyph(4'h2), 1'b0, 4);
    drive_digit(1, 7'b0000001, 1'b0, 4);
    drive_digit(0, glyph(4'h3), 1'b0, 4);
    exp.v = 16'h1203; exp.dp = 4'b0000; exp.bad = 4'b0010;
    sb_q.push_back(exp);
    wait_valid(30, ok);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || out_bad !== exp.bad || out_value !== exp.v || out_dp !== exp.dp) begin
      n_bad++;
      $display("FAIL bad_glyph: got ok=%b %h/%b/%b want %h/%b/%b", ok, out_value, out_dp, out_bad, exp.v, exp.dp, exp.bad);
    end
    repeat (2) tick();
    $display("dp_bad: frames EFB0 and 1203");
  endtask

  task automatic test_back_to_back();
    frame_t exp;
    bit ok;
    out_ready = 1'b0;
    send_frame(16'h1357, 4'b0000, 6, 1'b1);
    wait_valid(30, ok);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || out_value !== exp.v) begin
      n_bad++;
      $display("FAIL b2b_first: got ok=%b value=%h want %h", ok, out_value, exp.v);
    end
    send_frame(16'h2468, 4'b0000, 6, 1'b1);
    // The current cycle is the COMMIT of the second frame: accept and reload together.
    out_ready = 1'b1;
    tick();
    exp = sb_q.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || out_value !== exp.v || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_reload: got valid=%b value=%h overrun=%b want 1/%h/0", out_valid, out_value, overrun, exp.v);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain: got valid=%b want 0", out_valid);
    end
    $display("back_to_back: frames 1357 and 2468");
  endtask

  task automatic test_overrun();
    frame_t exp;
    bit ok;
    out_ready = 1'b0;
    send_frame(16'hAAAA, 4'b0000, 6, 1'b1);
    wait_valid(30, ok);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || out_value !== exp.v) begin
      n_bad++;
      $display("FAIL ovr_first: got ok=%b value=%h want %h", ok, out_value, exp.v);
    end
    send_frame(16'h5555, 4'b0000, 6, 1'b0);
    repeat (4) tick();
    n_vec++;
    if (out_value !== exp.v || out_valid !== 1'b1 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_hold: got value=%h valid=%b overrun=%b want %h/1/1", out_value, out_valid, overrun, exp.v);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_drain: got valid=%b overrun=%b want 0/1", out_valid, overrun);
    end
    out_ready = 1'b1;
    tick();
    $display("overrun: kept %h, dropped 5555", exp.v);
  endtask

  task automatic test_invalid_an_reset();
    frame_t exp;
    bit ok;
    bit seen;
    out_ready = 1'b1;
    drive_digit(3, glyph(4'hC), 1'b0, 6);
    drive_digit(2, glyph(4'hD), 1'b0, 6);
    seen = 1'b0;
    an = 4'b0011;
    seg = {glyph(4'h8), 1'b0};
    for (int i = 0; i < 20; i++) begin
      if (i == 10) an = 4'b0000;
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_bad++;
      $display("FAIL invalid_an_valid: got valid=1 during non-one-hot an want 0");
    end
    drive_digit(1, glyph(4'hE), 1'b0, 6);
    drive_digit(0, glyph(4'hF), 1'b0, 6);
    exp.v = 16'hCDEF; exp.dp = 4'b0000; exp.bad = 4'b0000;
    sb_q.push_back(exp);
    wait_valid(30, ok);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || out_value !== exp.v) begin
      n_bad++;
      $display("FAIL invalid_an_frame: got ok=%b value=%h want %h", ok, out_value, exp.v);
    end
    tick();
    drive_digit(3, glyph(4'h1), 1'b0, 6);
    drive_digit(2, glyph(4'h2), 1'b0, 6);
    an = 4'b0000;
    rst = 1'b1;
    repeat (2) tick();
    n_vec++;
    if (out_value !== 16'h0 || out_dp !== 4'h0 || out_bad !== 4'h0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_reset: got %h/%b/%b valid=%b overrun=%b want zeros", out_value, out_dp, out_bad, out_valid, overrun);
    end
    rst = 1'b0;
    drive_digit(1, glyph(4'h3), 1'b0, 6);
    drive_digit(0, glyph(4'h4), 1'b0, 6);
    an = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_bad++;
      $display("FAIL reset_discard: got valid=1 with only two digits after reset want 0");
    end
    drive_digit(3, glyph(4'h5), 1'b0, 6);
    drive_digit(2, glyph(4'h6), 1'b0, 6);
    exp.v = 16'h5634; exp.dp = 4'b0000; exp.bad = 4'b0000;
    sb_q.push_back(exp);
    wait_valid(30, ok);
    exp = sb_q.pop_front();
    n_vec++;
    if (!ok || out_value !== exp.v || out_bad !== exp.bad) begin
      n_bad++;
      $display("FAIL post_reset_frame: got ok=%b value=%h bad=%b want %h/%b", ok, out_value, out_bad, exp.v, exp.bad);
    end
    tick();
    $display("invalid_an_reset: frames CDEF and %h", exp.v);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_dp_bad();
    test_back_to_back();
    test_overrun();
    test_invalid_an_reset();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left: got %0d pending frames want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_to_hex_capture.md
SEG_TO_HEX_CAPTURE -- requirements
Module: seg_to_hex_capture

Interface
REQ-001 The block SHALL have the parameter STABLE_CYCLES, default 4, which is the number of consecutive identical cycles required to accept a digit; legal values are 2 to 255.
REQ-002 The block SHALL have the parameter SEG_ACTIVE_LOW, default 0; when 1, seg is inverted before decode.
REQ-003 The block SHALL have the parameter AN_ACTIVE_LOW, default 0; when 1, an is inverted before use.
REQ-004 The block SHALL have the port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port rst, input, width 1: a synchronous, active-high reset.
REQ-006 The block SHALL have the port seg, input, width [0:7]: seg[0..6] are segments a..g and seg[7] is the decimal point.
REQ-007 The block SHALL have the port an, input, width [3:0]: digit enables, one-hot, where an[k] selects digit k and k=3 is the most significant digit.
REQ-008 The block SHALL have the port out_value, output, width [15:0]: the captured hex nibbles, with digit k at bits [4k+3:4k].
REQ-009 The block SHALL have the port out_dp, output, width [3:0]: the captured decimal point per digit.
REQ-010 The block SHALL have the port out_bad, output, width [3:0]: per digit, 1 if the captured pattern is not a legal glyph.
REQ-011 The block SHALL have the port out_valid, output, width 1: out_value, out_dp and out_bad hold a complete frame.
REQ-012 The block SHALL have the port out_ready, input, width 1: the consumer accepts the frame when out_valid and out_ready are both 1.
REQ-013 The block SHALL have the port overrun, output, width 1: a sticky flag meaning a completed frame was dropped.

Function
REQ-014 Decode SHALL use seg[0:6] (abcdefg) mapped as follows:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001
- 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111
- C=1001110, d=0111101, E=1001111, F=1000111
REQ-015 Any other seg[0:6] pattern SHALL decode to nibble 0 with its bad bit set to 1; seg[7] SHALL be passed through as dp.
REQ-016 The sample SHALL be the registered pair {an, seg} after polarity correction; when an is not one-hot (zero or multiple bits set), the stability counter SHALL clear to 0 and no capture SHALL occur.
REQ-017 Stability counter behaviour SHALL be:
- if the sample is one-hot and equal to the previous cycle's sample, the counter increments, saturating at STABLE_CYCLES;
- otherwise, if the sample is one-hot, the counter loads 1.
REQ-018 A digit SHALL be captured exactly once per dwell: in the cycle the counter transitions to STABLE_CYCLES, slot k is written with {nibble, dp, bad} and mask[k] is set.
REQ-019 A recapture of a slot whose mask bit is already set SHALL overwrite that slot and leave the mask unchanged.
REQ-020 The FSM SHALL have two states, COLLECT and COMMIT:
- COLLECT moves to COMMIT on the cycle after mask becomes 4'b1111;
- COMMIT lasts one cycle, clears the mask, and returns to COLLECT.
REQ-021 In COMMIT, if out_valid is 0 or out_ready is 1, the output registers SHALL load the four slots and out_valid SHALL be 1 on the following cycle.
REQ-022 In COMMIT, if out_valid is 1 and out_ready is 0, the frame SHALL be discarded, the output registers SHALL be unchanged, and overrun SHALL be set to 1.
REQ-023 When a handshake (out_valid and out_ready both 1) occurs in a cycle other than a COMMIT load, out_valid SHALL be 0 on the next cycle.
REQ-024 When a handshake and a COMMIT load occur in the same cycle, out_valid SHALL stay 1 and the new frame SHALL be presented.
REQ-025 A capture occurring during COMMIT SHALL be recorded in the slot, and its mask bit SHALL be set after the clear.
REQ-026 Latency SHALL be as follows:
- the first cycle of a stable sample is the cycle it appears at the sample register;
- capture occurs STABLE_CYCLES-1 cycles after that first cycle;
- out_valid rises 2 cycles after the last mask bit is set.

Reset
REQ-027 When rst is 1 at a clock edge, the following SHALL be forced on the next cycle:
- out_value=16'h0000, out_dp=4'b0000, out_bad=4'b0000;
- out_valid=0, overrun=0;
- mask=0, counter=0, sample register=0, state=COLLECT.
REQ-028 A reset mid-dwell or mid-frame SHALL discard all partial captures.
REQ-029 While rst is 1, no capture or load SHALL occur.

Verification
REQ-030 Scenario 1: scan digits 3..0 with glyphs 1,2,3,4, each held 6 cycles, dp=0, out_ready=1 -> out_value=16'h1234, out_bad=0, out_valid high for 1 cycle.
REQ-031 Scenario 2: hold digit 0 with pattern 1111111 for 3 cycles, then switch to 0110000 (STABLE_CYCLES=4) -> no capture of 8; digit 0 captured as 1.
REQ-032 Scenario 3: frame E,F,b,0 with seg[7]=1 on digit 2, then glyph 0000001 on digit 1 in the next frame -> first frame out_value=16'hEFB0 with out_dp=4'b0100; second frame out_bad[1]=1 and nibble 1=0.
REQ-033 Scenario 4: out_ready=0, two full frames 16'hAAAA then 16'h5555 -> out_value stays 16'hAAAA and overrun=1; raise out_ready for 1 cycle -> out_valid=0.
REQ-034 Scenario 5: an=4'b0011 or 4'b0000 for 20 cycles -> no capture and mask unchanged; then assert rst mid-frame -> all outputs return to zero and the next full frame is captured cleanly.
REQ-035 Scenario 6: SEG_ACTIVE_LOW=1 and AN_ACTIVE_LOW=1 with inverted stimulus of scenario 1 -> out_value=16'h1234.
